// File: rtl/q_update.sv
// q_update: 24-entry Q table (6 states x 4 actions) with a temporal-difference
// update unit, one update in flight at a time.
//
// Ports:
//   CLK, RST          clock (rising edge) and synchronous active-high reset
//   in_valid/in_ready request handshake; accepted when both are high on an edge
//   addr              {state[2:0], action[1:0]}, valid range 0..23
//   Reward            signed Q8.16 reward
//   gamma_maxQ        signed Q8.16 discounted next-state maximum
//   Alpha             unsigned Q0.16 learning rate
//   q_new             last written Q value
//   done              one-cycle pulse, q_new valid
//   err               one-cycle pulse, out-of-range request dropped
//   Max_Q0..Max_Q5    registered signed max over the 4 actions of each state
module q_update #(
  parameter int unsigned Depth  = 24,
  parameter int unsigned Width  = 24,
  parameter int unsigned AlphaW = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$clog2(Depth)-1:0]  addr,
  input  logic [Width-1:0]          Reward,
  input  logic [Width-1:0]          gamma_maxQ,
  input  logic [AlphaW-1:0]         Alpha,
  output logic [Width-1:0]          q_new,
  output logic                      done,
  output logic                      err,
  output logic [Width-1:0]          Max_Q0,
  output logic [Width-1:0]          Max_Q1,
  output logic [Width-1:0]          Max_Q2,
  output logic [Width-1:0]          Max_Q3,
  output logic [Width-1:0]          Max_Q4,
  output logic [Width-1:0]          Max_Q5
);

  typedef enum logic [1:0] {StIdle, StTd, StUpd, StMax} state_e;

  localparam logic signed [26:0] SatHi = 27'sh07FFFFF;
  localparam logic signed [26:0] SatLo = 27'sh7800000;  // -2^23

  state_e r_state, w_state_next;

  logic signed [23:0] r_q [24];
  logic signed [23:0] r_max [6];
  logic [4:0]         r_addr;
  logic [23:0]        r_reward;
  logic [23:0]        r_gmq;
  logic [15:0]        r_alpha;
  logic signed [25:0] r_td;
  logic [23:0]        r_q_new;
  logic               r_done;
  logic               r_err;

  logic               w_accept;
  logic               w_bad_req;
  logic signed [23:0] w_q_cur;
  logic signed [25:0] w_td;
  logic signed [42:0] w_td_ext;
  logic signed [42:0] w_alpha_ext;
  logic signed [42:0] w_prod;
  logic signed [26:0] w_delta;
  logic signed [26:0] w_sum;
  logic signed [23:0] w_q_sat;
  logic signed [23:0] w_max_new;

  assign in_ready  = (r_state == StIdle);
  assign w_accept  = in_ready && in_valid && (addr < 5'd24);
  assign w_bad_req = in_ready && in_valid && (addr >= 5'd24);

  assign w_q_cur = r_q[r_addr];

  // Sum of three Q8.16 words fits exactly in 26 bits.
  assign w_td = {{2{r_reward[23]}}, r_reward} + {{2{r_gmq[23]}}, r_gmq}
              - {{2{w_q_cur[23]}}, w_q_cur};

  assign w_td_ext    = {{17{r_td[25]}}, r_td};
  assign w_alpha_ext = {27'd0, r_alpha};
  assign w_prod      = w_td_ext * w_alpha_ext;
  // Bit slice of the product is the arithmetic >>> 16 (floor toward -inf).
  assign w_delta     = w_prod[42:16];
  assign w_sum       = {{3{w_q_cur[23]}}, w_q_cur} + w_delta;

  always_comb begin
    w_q_sat = w_sum[23:0];
    if (w_sum > SatHi) begin
      w_q_sat = 24'sh7FFFFF;
    end else if (w_sum < SatLo) begin
      w_q_sat = 24'sh800000;
    end
  end

  always_comb begin
    w_max_new = r_q[{r_addr[4:2], 2'd0}];
    for (int k = 1; k < 4; k++) begin
      if (r_q[{r_addr[4:2], 2'(k)}] > w_max_new) begin
        w_max_new = r_q[{r_addr[4:2], 2'(k)}];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StTd;
      StTd:    w_state_next = StUpd;
      StUpd:   w_state_next = StMax;
      StMax:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_reward <= '0;
      r_gmq    <= '0;
      r_alpha  <= '0;
      r_td     <= '0;
      r_q_new  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < 24; i++) r_q[i] <= '0;
      for (int i = 0; i < 6; i++) r_max[i] <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == StUpd);
      r_err   <= w_bad_req;
      if (w_accept) begin
        r_addr   <= addr;
        r_reward <= Reward;
        r_gmq    <= gamma_maxQ;
        r_alpha  <= Alpha;
      end
      if (r_state == StTd) r_td <= w_td;
      if (r_state == StUpd) begin
        r_q[r_addr] <= w_q_sat;
        r_q_new     <= w_q_sat;
      end
      if (r_state == StMax) r_max[r_addr[4:2]] <= w_max_new;
    end
  end

  assign q_new  = r_q_new;
  assign done   = r_done;
  assign err    = r_err;
  assign Max_Q0 = r_max[0];
  assign Max_Q1 = r_max[1];
  assign Max_Q2 = r_max[2];
  assign Max_Q3 = r_max[3];
  assign Max_Q4 = r_max[4];
  assign Max_Q5 = r_max[5];

endmodule
